tone_detector: RTL and testbench



---
 rtl/tone_detector.sv | 156 +++++++++++++++
 tb/tb_tone_detector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// Tone detector: measures the rise-to-rise period of an asynchronous square
// wave and reports a confirmed tone A / tone B identity.
module tone_detector #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned PERIOD_A    = 113636,
    parameter int unsigned PERIOD_B    = 56818,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned CONFIRM     = 4,
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSOUND,
    output logic [CNT_W-1:0] oPERIOD,
    output logic             oPERIOD_STB,
    output logic             oTONE_VALID,
    output logic             oTONE_ID,
    output logic             oTIMEOUT
);

    localparam int unsigned MATCH_W = $clog2(CONFIRM + 1);

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    state_t             state, state_d;
    logic               s1, s2, s3;
    logic               rise;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   period_d;
    logic               stb_d, timeout_d, valid_d, id_d;
    logic [MATCH_W-1:0] match_cnt, match_d;
    logic               last_class, last_d;
    logic               hit_a, hit_b, cls_none, cls_b;

    // |p - nom| <= TOL, comparing before subtracting so the difference never wraps
    function automatic logic in_window(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] nom);
        logic [CNT_W-1:0] diff;
        diff = (p >= nom) ? (p - nom) : (nom - p);
        return diff <= CNT_W'(TOL);
    endfunction

    // Two-stage synchronizer plus edge-detect register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= iSOUND;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Classify the running count; only used on the cycle a rise closes a period
    always_comb begin
        hit_a    = in_window(cnt, CNT_W'(PERIOD_A));
        hit_b    = in_window(cnt, CNT_W'(PERIOD_B));
        cls_none = ~hit_a & ~hit_b;
        cls_b    = ~hit_a;
    end

    // State and datapath registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= WAIT_EDGE;
            cnt         <= '0;
            oPERIOD     <= '0;
            oPERIOD_STB <= 1'b0;
            oTIMEOUT    <= 1'b0;
            oTONE_VALID <= 1'b0;
            oTONE_ID    <= 1'b0;
            match_cnt   <= '0;
            last_class  <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            oPERIOD     <= period_d;
            oPERIOD_STB <= stb_d;
            oTIMEOUT    <= timeout_d;
            oTONE_VALID <= valid_d;
            oTONE_ID    <= id_d;
            match_cnt   <= match_d;
            last_class  <= last_d;
        end
    end

    // Next-state, period measurement, timeout and confirmation logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        period_d  = oPERIOD;
        stb_d     = 1'b0;
        timeout_d = 1'b0;
        valid_d   = oTONE_VALID;
        id_d      = oTONE_ID;
        match_d   = match_cnt;
        last_d    = last_class;

        case (state)
            WAIT_EDGE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt;
                    stb_d    = 1'b1;
                    cnt_d    = CNT_W'(1);
                    if (cls_none) begin
                        match_d = '0;
                        valid_d = 1'b0;
                    end else if ((match_cnt == '0) || (cls_b != last_class)) begin
                        last_d  = cls_b;
                        match_d = MATCH_W'(1);
                        valid_d = (CONFIRM == 1);
                        if (CONFIRM == 1) begin
                            id_d = cls_b;
                        end
                    end else begin
                        if (match_cnt >= MATCH_W'(CONFIRM)) begin
                            match_d = MATCH_W'(CONFIRM);
                        end else begin
                            match_d = match_cnt + MATCH_W'(1);
                        end
                        if (match_d == MATCH_W'(CONFIRM)) begin
                            valid_d = 1'b1;
                            id_d    = cls_b;
                        end
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    match_d   = '0;
                    cnt_d     = '0;
                    state_d   = WAIT_EDGE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_EDGE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tone_detector.sv
// Self-checking bench for tone_detector: timestamp-based reference model
// compared every cycle, a period table, and directed multi-cycle sequences.
module tb_tone_detector;

    localparam int unsigned CNT_W = 12;
    localparam int PA   = 100;
    localparam int PB   = 50;
    localparam int TOLR = 4;
    localparam int CONF = 3;
    localparam int TO   = 300;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             snd   = 1'b0;
    logic [CNT_W-1:0] period;
    logic             stb, valid, tone_id, tmo;

    tone_detector #(
        .CNT_W      (CNT_W),
        .PERIOD_A   (PA),
        .PERIOD_B   (PB),
        .TOL        (TOLR),
        .CONFIRM    (CONF),
        .TIMEOUT_CYC(TO)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iSOUND     (snd),
        .oPERIOD    (period),
        .oPERIOD_STB(stb),
        .oTONE_VALID(valid),
        .oTONE_ID   (tone_id),
        .oTIMEOUT   (tmo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (rise timestamps, not counters) -------------
    typedef struct {
        int per;
        bit valid;
        bit id;
        int k;
    } obs_t;
    obs_t obs_q[$];

    int k = 0;
    bit d0, d1, d2;
    bit meas;
    int last_rise;
    int run;
    int lcls;
    bit m_valid, m_id, m_stb, m_to;
    int m_period;
    int last_stb_k = 0;
    int to_k_last  = 0;
    int to_count   = 0;
    bit smp, mrise;

    function automatic int classify(input int p);
        int da, db;
        da = (p > PA) ? p - PA : PA - p;
        db = (p > PB) ? p - PB : PB - p;
        if (da <= TOLR) return 0;
        if (db <= TOLR) return 1;
        return 2;
    endfunction

    function automatic void confirm(input int p);
        int c;
        c = classify(p);
        if (c == 2) begin
            run = 0;
            m_valid = 1'b0;
        end else if (run == 0 || c != lcls) begin
            lcls = c;
            run = 1;
            m_valid = (CONF == 1);
            if (CONF == 1) m_id = c[0];
        end else begin
            run = (run + 1 > CONF) ? CONF : run + 1;
            if (run == CONF) begin
                m_valid = 1'b1;
                m_id = c[0];
            end
        end
    endfunction

    // Per-edge model step and full output comparison
    always @(posedge clk) begin
        smp = snd;
        #1;
        k++;
        if (!rst_n) begin
            d0 = 0; d1 = 0; d2 = 0;
            meas = 0; run = 0; lcls = 0; last_rise = 0;
            m_valid = 0; m_id = 0; m_stb = 0; m_to = 0; m_period = 0;
        end else begin
            // input sampled high at edge n is seen as a rise at edge n+2
            mrise = d1 & ~d2;
            d2 = d1; d1 = d0; d0 = smp;
            m_stb = 0; m_to = 0;
            if (mrise) begin
                if (meas) begin
                    m_period = k - last_rise;
                    m_stb = 1;
                    confirm(m_period);
                end
                meas = 1;
                last_rise = k;
            end else if (meas && (k - last_rise == TO)) begin
                m_to = 1;
                m_valid = 0;
                run = 0;
                meas = 0;
            end
        end
        check("period", 32'(period), 32'(m_period));
        check("stb", 32'(stb), 32'(m_stb));
        check("valid", 32'(valid), 32'(m_valid));
        check("id", 32'(tone_id), 32'(m_id));
        check("timeout", 32'(tmo), 32'(m_to));
        if (stb === 1'b1) begin
            obs_q.push_back('{int'(period), valid, tone_id, k});
            last_stb_k = k;
        end
        if (tmo === 1'b1) begin
            to_count++;
            to_k_last = k;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_period(input int per, input int high);
        snd = 1'b1;
        repeat (high) @(negedge clk);
        snd = 1'b0;
        repeat (per - high) @(negedge clk);
    endtask

    typedef struct {
        int per;
        bit valid;
        bit id;
    } vec_t;
    vec_t tbl[22];

    int n0;
    int per_r, t_r;

    initial begin
        tbl[0]  = '{100, 1'b0, 1'b0};
        tbl[1]  = '{100, 1'b0, 1'b0};
        tbl[2]  = '{100, 1'b1, 1'b0};
        tbl[3]  = '{100, 1'b1, 1'b0};
        tbl[4]  = '{50,  1'b0, 1'b0};
        tbl[5]  = '{50,  1'b0, 1'b0};
        tbl[6]  = '{50,  1'b1, 1'b1};
        tbl[7]  = '{104, 1'b0, 1'b1};
        tbl[8]  = '{104, 1'b0, 1'b1};
        tbl[9]  = '{104, 1'b1, 1'b0};
        tbl[10] = '{105, 1'b0, 1'b0};
        tbl[11] = '{96,  1'b0, 1'b0};
        tbl[12] = '{96,  1'b0, 1'b0};
        tbl[13] = '{96,  1'b1, 1'b0};
        tbl[14] = '{95,  1'b0, 1'b0};
        tbl[15] = '{54,  1'b0, 1'b0};
        tbl[16] = '{46,  1'b0, 1'b0};
        tbl[17] = '{54,  1'b1, 1'b1};
        tbl[18] = '{45,  1'b0, 1'b1};
        tbl[19] = '{100, 1'b0, 1'b1};
        tbl[20] = '{100, 1'b0, 1'b1};
        tbl[21] = '{100, 1'b1, 1'b0};

        // Reset held with a toggling input, then release with input low
        rst_n = 1'b0;
        repeat (10) @(negedge clk) snd = ~snd;
        check("rst_period", 32'(period), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_stb", 32'(stb), 0);
        check("rst_timeout", 32'(tmo), 0);
        snd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_strobes", 32'(obs_q.size()), 0);
        check("idle_valid", 32'(valid), 0);

        // Period table: strobe i reports period i with the listed confirmation
        obs_q.delete();
        for (int i = 0; i < 22; i++) drive_period(tbl[i].per, tbl[i].per / 2);
        snd = 1'b1;
        repeat (10) @(negedge clk);
        snd = 1'b0;
        check("tbl_strobes", 32'(obs_q.size()), 22);
        for (int i = 0; i < 22; i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("tbl%0d_period", i), 32'(obs_q[i].per), 32'(tbl[i].per));
                check($sformatf("tbl%0d_valid", i), 32'(obs_q[i].valid), 32'(tbl[i].valid));
                check($sformatf("tbl%0d_id", i), 32'(obs_q[i].id), 32'(tbl[i].id));
            end
        end

        // Input held low after a valid tone: one timeout pulse 300 cycles after last rise
        repeat (330) @(negedge clk);
        check("to_count", 32'(to_count), 1);
        check("to_delay", 32'(to_k_last - last_stb_k), 32'(TO));
        check("to_valid", 32'(valid), 0);
        n0 = obs_q.size();
        drive_period(100, 50);
        check("restart_no_stb", 32'(obs_q.size() - n0), 0);
        drive_period(100, 50);
        check("restart_stb", 32'(obs_q.size() - n0), 1);
        if (obs_q.size() > n0) begin
            check("restart_period", 32'(obs_q[n0].per), 100);
            check("restart_valid", 32'(obs_q[n0].valid), 0);
        end
        drive_period(100, 50);
        drive_period(100, 50);
        snd = 1'b1;
        repeat (20) @(negedge clk);
        check("prereset_valid", 32'(valid), 1);

        // Asynchronous reset mid-period clears outputs without a clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 0);
        check("arst_period", 32'(period), 0);
        check("arst_stb", 32'(stb), 0);
        check("arst_timeout", 32'(tmo), 0);
        repeat (3) @(negedge clk);
        snd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = obs_q.size();
        repeat (4) drive_period(100, 50);
        check("reval_strobes", 32'(obs_q.size() - n0), 3);
        if (obs_q.size() >= n0 + 3) begin
            check("reval_2nd_valid", 32'(obs_q[n0 + 1].valid), 0);
            check("reval_3rd_valid", 32'(obs_q[n0 + 2].valid), 1);
            check("reval_3rd_id", 32'(obs_q[n0 + 2].id), 0);
        end

        // Randomized periods, duty cycles and dropouts against the model
        for (int i = 0; i < 45; i++) begin
            t_r = int'($urandom_range(0, 9));
            if (i == 5) per_r = TO;
            else if (i == 6) per_r = TO + 1;
            else if (t_r <= 3) per_r = 96 + int'($urandom_range(0, 9));
            else if (t_r <= 6) per_r = 45 + int'($urandom_range(0, 10));
            else per_r = int'($urandom_range(20, 320));
            if (t_r == 9 && i > 6) begin
                snd = 1'b0;
                repeat (350) @(negedge clk);
            end else begin
                drive_period(per_r, int'($urandom_range(1, per_r - 1)));
            end
        end
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
